// File: rtl/dest_sel_pkg.sv
// ----------------------------------------------------------------------------
// dest_sel_pkg
// Shared constants for the execute-stage destination-register select pipe.
//   REG_ADDR_W      : width of an architectural register address
//   LINK_REG        : register written by jump-and-link style instructions
//   SEL_RT/RD/LINK  : candidate index of each conventional destination source
//   DEF_BUBBLE_VAL  : default data for empty slots (register 0, writes ignored)
// ----------------------------------------------------------------------------
package dest_sel_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;

   // Candidate ordering inside the flattened in_data bus.
   localparam int SEL_RT   = 0;
   localparam int SEL_RD   = 1;
   localparam int SEL_LINK = 2;

   // Bubbles target register 0 so a stray downstream write is harmless.
   localparam int DEF_BUBBLE_VAL = 0;

endpackage : dest_sel_pkg

// File: rtl/dest_sel_stage.sv
// ----------------------------------------------------------------------------
// dest_sel_stage
// One valid/data/err register slot of the destination-select pipe.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   i_stall       : hold current contents
//   i_flush       : load a bubble (wins over i_stall)
//   i_valid/i_data/i_err : slot contents from the previous stage or select
//   o_valid/o_data/o_err : registered slot contents
// Valid tagging: o_valid marks o_data/o_err as a real item; when o_valid is 0
// the slot is a bubble and carries BUBBLE_VAL with err cleared. There is no
// backpressure other than the global stall.
// ----------------------------------------------------------------------------
module dest_sel_stage
   import dest_sel_pkg::*;
#(
   parameter int                WIDTH      = REG_ADDR_W,
   parameter logic [WIDTH-1:0]  BUBBLE_VAL = WIDTH'(DEF_BUBBLE_VAL)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_err,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_err
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= BUBBLE_VAL;
         r_err   <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_data  <= BUBBLE_VAL;
         r_err   <= 1'b0;
      end else if (!i_stall) begin
         r_valid <= i_valid;
         r_data  <= i_data;
         r_err   <= i_err;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_err   = r_err;

endmodule : dest_sel_stage

// File: rtl/dest_sel_pipe.sv
// ----------------------------------------------------------------------------
// dest_sel_pipe
// Selects one of NUM_IN destination-register candidates and carries the
// result through STAGES registered slots toward the EX/MEM destination field.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : candidates and sel are meaningful this cycle
//   in_data    : flattened candidates, candidate i at [i*WIDTH +: WIDTH]
//   sel        : binary candidate index
//   stall      : freeze every stage (inputs in that cycle are dropped)
//   flush      : turn every stage into a bubble (wins over stall)
//   out_valid  : last stage holds a real item
//   out_data   : last stage data (BUBBLE_VAL for bubbles and bad selects)
// sel_err    : last stage holds an item whose sel had no candidate
// Valid tagging: an item enters when in_valid=1 on an edge with stall=0 and
// flush=0, and shows on out_* exactly STAGES such edges later. Nothing is
// held back for the caller; stalled inputs are simply not captured.
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module dest_sel_pipe
   import dest_sel_pkg::*;
#(
   parameter int                WIDTH      = REG_ADDR_W,
   parameter int                NUM_IN     = 3,
   parameter int                SEL_W      = 2,
   parameter int                STAGES     = 1,
   parameter logic [WIDTH-1:0]  BUBBLE_VAL = WIDTH'(DEF_BUBBLE_VAL)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    stall,
   input  logic                    flush,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic                    sel_err
);

   // Combinational candidate select. Indices >= NUM_IN fall through to the
   // bubble value with w_bad set.
   logic [WIDTH-1:0] w_mux;
   logic             w_bad;

   always_comb begin
      w_mux = BUBBLE_VAL;
      w_bad = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel == SEL_W'(i)) begin
            w_mux = in_data[i*WIDTH +: WIDTH];
            w_bad = 1'b0;
         end
      end
   end

   // Stage 0 input: bubbles are zeroed here so later stages just copy.
   logic             w_valid [0:STAGES];
   logic [WIDTH-1:0] w_data  [0:STAGES];
   logic             w_err   [0:STAGES];

   assign w_valid[0] = in_valid;
   assign w_data[0]  = in_valid ? w_mux : BUBBLE_VAL;
   assign w_err[0]   = in_valid & w_bad;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      dest_sel_stage #(
         .WIDTH      (WIDTH),
         .BUBBLE_VAL (BUBBLE_VAL)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_stall (stall),
         .i_flush (flush),
         .i_valid (w_valid[g]),
         .i_data  (w_data[g]),
         .i_err   (w_err[g]),
         .o_valid (w_valid[g+1]),
         .o_data  (w_data[g+1]),
         .o_err   (w_err[g+1])
      );
   end

   assign out_valid = w_valid[STAGES];
   assign out_data  = w_data[STAGES];
   assign sel_err   = w_err[STAGES];

endmodule : dest_sel_pipe
